fifo_push_arbiter: RTL

Round-robin arbiter that shares the push side of one 4-entry `fifo` among `NUM_REQ` requesters, typically state machines that write into a common RX path. It selects one requester per cycle and drives the FIFO's `push_en`/`data_in` from that requester's data. It gates grants on the FIFO `full` status. It also supports locked multi-word bursts so that one requester's words land contiguously in the FIFO.

---
 rtl/fifo_push_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter sharing one FIFO write port among NUM_REQ requesters, with burst locking.
// Optional per-requester stall counters are built only when FIFO_ARB_STALL_CNT_EN is defined.
module fifo_push_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      fifo_full,
  output logic                      fifo_push_en,
  output logic [DATA_W-1:0]         fifo_data,
  output logic                      locked,
  input  logic                      stall_clr,
  output logic [NUM_REQ*CNT_W-1:0]  stall_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;

  logic             gnt_vld;
  logic [IDX_W-1:0] gnt_idx;
  logic             xfer;
  logic             xfer_last;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + IDX_W'(1);
  endfunction

  // Winner selection: scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    int j;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    j       = 0;
    if (!fifo_full) begin
      if (state_q == LOCKED) begin
        if (req[owner_q]) begin
          gnt_vld = 1'b1;
          gnt_idx = owner_q;
        end
      end else begin
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          j = (int'(ptr_q) + k) % NUM_REQ;
          if (req[j]) begin
            gnt_vld = 1'b1;
            gnt_idx = IDX_W'(j);
          end
        end
      end
    end
  end

  assign xfer      = gnt_vld;
  assign xfer_last = req_last[gnt_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (xfer) begin
      case (state_q)
        IDLE: begin
          if (xfer_last) begin
            ptr_d = next_idx(gnt_idx);
          end else begin
            state_d = LOCKED;
            owner_d = gnt_idx;
          end
        end
        LOCKED: begin
          if (xfer_last) begin
            state_d = IDLE;
            ptr_d   = next_idx(owner_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    grant     = '0;
    fifo_data = '0;
    if (gnt_vld) begin
      grant[gnt_idx] = 1'b1;
      fifo_data      = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
    end
    fifo_push_en = |(req & grant);
    locked       = (state_q == LOCKED);
  end

`ifdef FIFO_ARB_STALL_CNT_EN
  logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // A requester stalls when it asks but is not granted; counters saturate instead of wrapping.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stall_clr) begin
        cnt_d[i] = '0;
      end else if (req[i] && !grant[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;
`else
  logic unused_stall_clr;
  assign unused_stall_clr = stall_clr;
  assign stall_cnt        = '0;
`endif

endmodule
